// File: rtl/mux_tx_pkg.sv
// Shared definitions for the transmit-side 2:1 burst interleaver:
// one-hot FSM encoding and default sizing.
package mux_tx_pkg;

    localparam int DEF_DEPTH     = 4;
    localparam int DEF_MAX_BURST = 8;

    typedef enum logic [6:0] {
        RESET  = 7'd1,
        W_0    = 7'd2,
        SEND_0 = 7'd4,
        GAP_0  = 7'd8,
        W_1    = 7'd16,
        SEND_1 = 7'd32,
        GAP_1  = 7'd64
    } state_t;

endpackage

// File: rtl/fifo_lane.sv
// DEPTH x 8 synchronous FIFO for one lane; a full FIFO drops writes unless a
// pop happens on the same edge, and a drop latches the sticky overflow flag.
module fifo_lane
    import mux_tx_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push) r_ovf <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers and count define which entries
    // are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/mux_tx.sv
// Interleaves two buffered lanes onto one valid-qualified stream as strictly
// alternating bursts (lane 0 first), with a valid-low gap after every burst.
module mux_tx
    import mux_tx_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic       clk2f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    output logic [7:0] data_out_c,
    output logic       valid_out_c,
    output logic       full_0,
    output logic       full_1,
    output logic       ovf_0,
    output logic       ovf_1
);

    localparam int         CW    = $clog2(DEPTH) + 1;
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_burst;
    logic [7:0]    w_burst_next;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          w_pop_0;
    logic          w_pop_1;
    logic [7:0]    w_head_0;
    logic [7:0]    w_head_1;
    logic [CW-1:0] w_count_0;
    logic [CW-1:0] w_count_1;

    fifo_lane #(.DEPTH(DEPTH)) u_fifo_0 (
        .clk     (clk2f),
        .rst_n   (reset),
        .i_push  (valid_in_0),
        .i_data  (data_in_0),
        .i_pop   (w_pop_0),
        .o_data  (w_head_0),
        .o_count (w_count_0),
        .o_full  (full_0),
        .o_ovf   (ovf_0)
    );

    fifo_lane #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk     (clk2f),
        .rst_n   (reset),
        .i_push  (valid_in_1),
        .i_data  (data_in_1),
        .i_pop   (w_pop_1),
        .o_data  (w_head_1),
        .o_count (w_count_1),
        .o_full  (full_1),
        .o_ovf   (ovf_1)
    );

    always_ff @(posedge clk2f) begin
        if (!reset) begin
            r_state <= RESET;
            r_burst <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_burst <= w_burst_next;
            r_data  <= w_pop_0 ? w_head_0 : (w_pop_1 ? w_head_1 : 8'h00);
            r_valid <= w_pop_0 || w_pop_1;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_burst_next = r_burst;
        w_pop_0      = 1'b0;
        w_pop_1      = 1'b0;
        case (r_state)
            RESET: begin
                w_next_state = W_0;
                w_burst_next = '0;
            end
            W_0: begin
                if (w_count_0 != '0) begin
                    w_pop_0      = 1'b1;
                    w_next_state = SEND_0;
                    w_burst_next = 8'd1;
                end
            end
            SEND_0: begin
                if ((w_count_0 != '0) && (r_burst < MAX_B)) begin
                    w_pop_0      = 1'b1;
                    w_burst_next = r_burst + 8'd1;
                end else begin
                    w_next_state = GAP_0;
                    w_burst_next = '0;
                end
            end
            GAP_0: w_next_state = W_1;
            W_1: begin
                if (w_count_1 != '0) begin
                    w_pop_1      = 1'b1;
                    w_next_state = SEND_1;
                    w_burst_next = 8'd1;
                end
            end
            SEND_1: begin
                if ((w_count_1 != '0) && (r_burst < MAX_B)) begin
                    w_pop_1      = 1'b1;
                    w_burst_next = r_burst + 8'd1;
                end else begin
                    w_next_state = GAP_1;
                    w_burst_next = '0;
                end
            end
            GAP_1: w_next_state = W_0;
            default: begin
                w_next_state = RESET;
                w_burst_next = '0;
            end
        endcase
    end

    assign data_out_c  = r_data;
    assign valid_out_c = r_valid;

endmodule
